// File: rtl/wavelet_pkg.sv
// Shared types and helpers for the wavelet obuff writer.
// Saturation is only used when WAVELET_OBUFF_WRITER_SAT_EN is defined.
package wavelet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    COLLECT,
    WRITE_HI,
    DONE
  } wr_state_t;

  localparam int unsigned LO_BASE = 0;

  function automatic int unsigned hi_base_init(input int unsigned cell_count);
    return cell_count / 2;
  endfunction

  // acc must already be sign-extended to 64 bits; result is clamped to out_w signed range
  function automatic logic [63:0] saturate(input logic signed [63:0] acc,
                                           input int unsigned out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (acc > max_v) return max_v;
    else if (acc < min_v) return min_v;
    else return acc;
  endfunction

endpackage

// File: rtl/wavelet_sat_trunc.sv
// Combinational FIR accumulator to obuff word conversion.
// WAVELET_OBUFF_WRITER_SAT_EN selects signed saturation, otherwise low-bit truncation.
module wavelet_sat_trunc
  import wavelet_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned INPUT_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  output logic [INPUT_WIDTH-1:0] data
);

`ifdef WAVELET_OBUFF_WRITER_SAT_EN
  logic signed [63:0] acc_ext;

  assign acc_ext = 64'(signed'(acc));
  assign data    = INPUT_WIDTH'(saturate(acc_ext, INPUT_WIDTH));
`else
  if (ACC_WIDTH > INPUT_WIDTH) begin : g_drop
    logic unused_hi;
    assign unused_hi = ^acc[ACC_WIDTH-1:INPUT_WIDTH];
  end
  assign data = acc[INPUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/wavelet_obuff_writer.sv
// Writes per-level lo/hi FIR results into obuff, dropping warm-up and optional odd samples.
// Build option: WAVELET_OBUFF_WRITER_SAT_EN (saturating data conversion).
module wavelet_obuff_writer
  import wavelet_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH      = 32,
  parameter int unsigned ACC_WIDTH        = 40,
  parameter int unsigned OBUFF_CELL_COUNT = 4096,
  parameter int unsigned IBUFF_CELL_COUNT = 2048,
  parameter int unsigned MAX_FILTER_SIZE  = 32,
  parameter int unsigned FS_WIDTH         = $clog2(MAX_FILTER_SIZE),
  parameter int unsigned OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
  parameter int unsigned IBUFF_ADDR_WIDTH = $clog2(IBUFF_CELL_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        level_start,
  input  logic                        clear_hi_base,
  input  logic [FS_WIDTH-1:0]         core_filter_size,
  input  logic                        core_downsample,
  input  logic [IBUFF_ADDR_WIDTH-1:0] cur_abs_inputs_len,
  input  logic                        pause_work,
  input  logic                        fir_valid,
  output logic                        fir_ready,
  input  logic [ACC_WIDTH-1:0]        fir_lo_data,
  input  logic [ACC_WIDTH-1:0]        fir_hi_data,
  output logic                        obuff_w_en,
  output logic [OBUFF_ADDR_WIDTH-1:0] obuff_w_addr,
  output logic [INPUT_WIDTH-1:0]      obuff_w_data,
  output logic                        job_done,
  output logic                        busy,
  output logic                        overflow_err
);

  localparam int unsigned HB_W  = OBUFF_ADDR_WIDTH + 1;
  localparam int unsigned SUM_W = ((HB_W > IBUFF_ADDR_WIDTH) ? HB_W : IBUFF_ADDR_WIDTH) + 1;
  localparam logic [SUM_W-1:0] DEPTH    = SUM_W'(OBUFF_CELL_COUNT);
  localparam logic [SUM_W-1:0] LO_LIMIT = SUM_W'(hi_base_init(OBUFF_CELL_COUNT));
  localparam logic [HB_W-1:0]  HB_INIT  = HB_W'(hi_base_init(OBUFF_CELL_COUNT));

  wr_state_t                   state;
  logic [FS_WIDTH-1:0]         skip_q;
  logic [FS_WIDTH-1:0]         skip_cnt;
  logic                        ds_q;
  logic                        phase;
  logic [IBUFF_ADDR_WIDTH-1:0] k_total;
  logic [IBUFF_ADDR_WIDTH-1:0] k_cnt;
  logic [HB_W-1:0]             hi_base;
  logic [INPUT_WIDTH-1:0]      hi_hold;

  logic [INPUT_WIDTH-1:0]      lo_conv;
  logic [INPUT_WIDTH-1:0]      hi_conv;
  logic [FS_WIDTH-1:0]         skip_in;
  logic [IBUFF_ADDR_WIDTH-1:0] k_in;
  logic [SUM_W-1:0]            lo_addr_full;
  logic [SUM_W-1:0]            hi_addr_full;
  logic [SUM_W-1:0]            hi_base_next;
  logic                        xfer;
  logic                        keep;
  logic                        lo_oob;
  logic                        hi_oob;

  wavelet_sat_trunc #(.ACC_WIDTH(ACC_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)) u_conv_lo (
    .acc  (fir_lo_data),
    .data (lo_conv)
  );

  wavelet_sat_trunc #(.ACC_WIDTH(ACC_WIDTH), .INPUT_WIDTH(INPUT_WIDTH)) u_conv_hi (
    .acc  (fir_hi_data),
    .data (hi_conv)
  );

  assign skip_in = (core_filter_size == '0) ? '0 : core_filter_size - 1'b1;
  assign k_in    = core_downsample
                 ? (cur_abs_inputs_len >> 1) + IBUFF_ADDR_WIDTH'(cur_abs_inputs_len[0])
                 : cur_abs_inputs_len;

  assign fir_ready    = ~pause_work & ((state == SKIP) | (state == COLLECT));
  assign xfer         = fir_valid & fir_ready;
  assign keep         = ~phase | ~ds_q;
  assign lo_addr_full = SUM_W'(LO_BASE) + SUM_W'(k_cnt);
  assign hi_addr_full = SUM_W'(hi_base) + SUM_W'(k_cnt);
  assign hi_base_next = SUM_W'(hi_base) + SUM_W'(k_total);
  assign lo_oob       = lo_addr_full >= LO_LIMIT;
  assign hi_oob       = hi_addr_full >= DEPTH;

  // lo goes out combinationally in the accept cycle; hi from the hold register one cycle later
  always_comb begin
    obuff_w_en   = 1'b0;
    obuff_w_addr = '0;
    obuff_w_data = '0;
    if (state == COLLECT && xfer && keep && !lo_oob) begin
      obuff_w_en   = 1'b1;
      obuff_w_addr = OBUFF_ADDR_WIDTH'(lo_addr_full);
      obuff_w_data = lo_conv;
    end else if (state == WRITE_HI && !pause_work && !hi_oob) begin
      obuff_w_en   = 1'b1;
      obuff_w_addr = OBUFF_ADDR_WIDTH'(hi_addr_full);
      obuff_w_data = hi_hold;
    end
  end

  assign job_done = (state == DONE) & ~pause_work;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      skip_q       <= '0;
      skip_cnt     <= '0;
      ds_q         <= 1'b0;
      phase        <= 1'b0;
      k_total      <= '0;
      k_cnt        <= '0;
      hi_base      <= HB_INIT;
      hi_hold      <= '0;
      overflow_err <= 1'b0;
    end else if (!pause_work) begin
      case (state)
        IDLE: begin
          if (clear_hi_base) begin
            hi_base      <= HB_INIT;
            overflow_err <= 1'b0;
          end
          if (level_start) begin
            skip_q   <= skip_in;
            ds_q     <= core_downsample;
            k_total  <= k_in;
            skip_cnt <= '0;
            k_cnt    <= '0;
            phase    <= 1'b0;
            if (skip_in != '0)   state <= SKIP;
            else if (k_in == '0) state <= DONE;
            else                 state <= COLLECT;
          end
        end
        SKIP: begin
          if (xfer) begin
            if (skip_cnt + 1'b1 == skip_q) begin
              skip_cnt <= '0;
              phase    <= 1'b0;
              state    <= (k_total == '0) ? DONE : COLLECT;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
        end
        COLLECT: begin
          if (xfer) begin
            phase <= ~phase;
            if (keep) begin
              hi_hold <= hi_conv;
              state   <= WRITE_HI;
              if (lo_oob) overflow_err <= 1'b1;
            end
          end
        end
        WRITE_HI: begin
          if (hi_oob) overflow_err <= 1'b1;
          k_cnt <= k_cnt + 1'b1;
          state <= (k_cnt + 1'b1 == k_total) ? DONE : COLLECT;
        end
        DONE: begin
          // clamp keeps later levels out of range instead of letting hi_base wrap
          if (clear_hi_base) begin
            hi_base      <= HB_INIT;
            overflow_err <= 1'b0;
          end else if (hi_base_next >= DEPTH) begin
            hi_base <= HB_W'(DEPTH);
          end else begin
            hi_base <= HB_W'(hi_base_next);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wavelet_obuff_writer.md
Name: wavelet_obuff_writer

Overview:
- Downstream neighbour of the wavelet core controller, beside the PE.
- Collects low-pass/high-pass FIR result pairs for one decomposition level, discards warm-up samples and optionally downsamples by 2.
- Writes approximation coefficients to the obuff low region (re-read by the controller's write-back) and appends detail coefficients to a growing high region.
- Raises a one-cycle job-done pulse at level end, which drives the controller's pe_job_done.

Parameters:
- INPUT_WIDTH, 32, obuff word width.
- ACC_WIDTH, 40, FIR accumulator width (>= INPUT_WIDTH).
- OBUFF_CELL_COUNT, 4096, obuff depth.
- IBUFF_CELL_COUNT, 2048, ibuff depth; sizes the length input.
- MAX_FILTER_SIZE, 32, maximum taps.
- FS_WIDTH, $clog2(MAX_FILTER_SIZE), filter size width.
- OBUFF_ADDR_WIDTH, $clog2(OBUFF_CELL_COUNT), obuff address width.
- IBUFF_ADDR_WIDTH, $clog2(IBUFF_CELL_COUNT), length width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- level_start  in  1  pulse: latch config, begin a level.
- clear_hi_base  in  1  pulse: hi_base <= OBUFF_CELL_COUNT/2 (first level of a core_go).
- core_filter_size  in  FS_WIDTH  taps F.
- core_downsample  in  1  keep every other sample.
- cur_abs_inputs_len  in  IBUFF_ADDR_WIDTH  input length L.
- pause_work  in  1  global freeze.
- fir_valid  in  1  result pair valid.
- fir_ready  out  1  writer accepts pair.
- fir_lo_data  in  ACC_WIDTH  low-pass result.
- fir_hi_data  in  ACC_WIDTH  high-pass result.
- obuff_w_en  out  1  write strobe.
- obuff_w_addr  out  OBUFF_ADDR_WIDTH  write address.
- obuff_w_data  out  INPUT_WIDTH  write data.
- job_done  out  1  one-cycle level-complete pulse.
- busy  out  1  level in progress.
- overflow_err  out  1  sticky: high region exceeded depth.

Behaviour:
- Reset values: every output 0, state IDLE, hi_base = OBUFF_CELL_COUNT/2, counters 0.
- Config is latched on level_start: F, downsample, L.
  - K = downsample ? ceil(L/2) : L.
  - skip = F-1.
- Handshake: a transfer occurs when fir_valid & fir_ready.
  - fir_ready = ~pause_work & state in {SKIP, COLLECT}.
- pause_work freezes state, counters and held data, and forces obuff_w_en=0 and fir_ready=0; job_done is not issued while paused.
- States:
  - IDLE: level_start -> skip==0 ? COLLECT : SKIP. clear_hi_base is honoured in IDLE or DONE only and takes priority over DONE's hi_base update.
  - SKIP: each transfer is discarded, skip_cnt++. Reaching skip -> COLLECT; phase=0.
  - COLLECT: each transfer toggles phase. If phase==0 or ~downsample, the sample is kept:
    - same cycle: write lo to addr k.
    - hold hi; go to WRITE_HI.
    - discarded samples stay in COLLECT.
  - WRITE_HI: write held hi to hi_base+k, k++, fir_ready=0. Then k==K -> DONE, else COLLECT.
  - DONE: job_done=1 for one cycle; hi_base += K -> IDLE.
- Write latency: lo is written in the accept cycle; hi is written the next unpaused cycle. Throughput is at most one kept pair per 2 cycles.
- Data: ACC_WIDTH -> INPUT_WIDTH conversion; see Optional Feature.
- Overflow: if hi_base+k >= OBUFF_CELL_COUNT, the hi write is suppressed, overflow_err=1 (sticky until reset or clear_hi_base) and the counter still advances.
  - The lo region is [0, OBUFF_CELL_COUNT/2); K above that also sets the error and suppresses the write.
- level_start outside IDLE is ignored.
- L=0: K=0; enter DONE straight after skip completes.
- busy = state != IDLE.
- Asynchronous reset mid-level aborts with no partial done pulse.

Optional Feature:
- Macro WAVELET_OBUFF_WRITER_SAT_EN.
- Defined: signed saturation of ACC_WIDTH results to INPUT_WIDTH range (max 0x7FFFFFFF, min 0x80000000 at defaults).
- Undefined: plain truncation to the low INPUT_WIDTH bits.

Decomposition:
- Package wavelet_pkg: state enum (IDLE, SKIP, COLLECT, WRITE_HI, DONE), LO_BASE=0, HI_BASE_INIT=OBUFF_CELL_COUNT/2 function, saturate function.
- One sub-module: wavelet_sat_trunc (combinational ACC->INPUT conversion, macro-controlled), instantiated twice (lo, hi).
- Existing register module reused for the hi hold register.

Test Plan:
- F=4, L=8, downsample=0, clear_hi_base then level_start, 11 pairs -> first 3 dropped; lo writes addr 0..7, hi writes 2048..2055; job_done one cycle after last hi write; hi_base=2056.
- F=2, L=7, downsample=1 -> K=4; kept samples 0,2,4,6 post-skip; lo 0..3, hi 2048..2051; second level L=4 appends hi 2052..2053.
- Continuous fir_valid -> fir_ready low every WRITE_HI cycle; no pair lost or duplicated (scoreboard count == K).
- pause_work asserted 5 cycles mid-COLLECT and during WRITE_HI -> no writes, state and addresses unchanged, resumes with correct addresses.
- hi_base near 4094, K=4 -> two writes land, overflow_err=1, remaining hi writes suppressed, job_done still pulses.
- fir_lo_data=0x7F_FFFF_FFFF with SAT_EN -> 0x7FFFFFFF; without -> 0xFFFFFFFF; async reset mid-level -> all outputs 0 immediately, no job_done.
